// File: rtl/fir_stim_pkg.sv
// Shared definitions for the FIR stimulus source: mode codes, FSM states
// and the default Galois LFSR tap mask.
package fir_stim_pkg;

  typedef enum logic [1:0] {
    MODE_CONST   = 2'd0,
    MODE_IMPULSE = 2'd1,
    MODE_RAMP    = 2'd2,
    MODE_LFSR    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // x^8 + x^6 + x^5 + x^4 + 1 in right-shifting Galois form
  localparam logic [7:0] LFSR_TAPS_W8 = 8'hB8;

endpackage

// File: rtl/fir_stim_if.sv
// Sample stream between the stimulus source (master) and the FIR input (slave).
interface fir_stim_if #(
  parameter int WIDTH_DATA = 8
);
  logic [WIDTH_DATA-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/fir_stim_lfsr.sv
// Galois LFSR that runs one step ahead: load captures step(seed), so state
// always holds the sample following the one currently on dout.
module fir_stim_lfsr
  import fir_stim_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_W8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_r;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    if (s[0]) begin
      return (s >> 1) ^ TAPS;
    end else begin
      return s >> 1;
    end
  endfunction

  // LFSR state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= {WIDTH{1'b0}};
    end else if (load) begin
      state_r <= lfsr_step(seed);
    end else if (advance) begin
      state_r <= lfsr_step(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/fir_stim_source.sv
// Burst sample generator feeding the FIR input. Define FIR_STIM_LFSR_EN to
// build the pseudo-random mode; without it mode 3 emits zeros.
module fir_stim_source
  import fir_stim_pkg::*;
#(
  parameter int WIDTH_DATA = 8,
  parameter int LOG2_LEN   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [WIDTH_DATA-1:0] amplitude,
  input  logic [LOG2_LEN-1:0]   length,
  output logic                  busy,
  output logic                  done,
  fir_stim_if.master            sif
);

  state_e                state_r;
  mode_e                 mode_r;
  logic [WIDTH_DATA-1:0] amp_r;
  logic [WIDTH_DATA-1:0] dout_r;
  logic [LOG2_LEN-1:0]   len_r;
  logic [LOG2_LEN-1:0]   cnt_r;
  logic                  valid_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  xfer_s;
  logic [LOG2_LEN-1:0]   cnt_inc_s;
  logic [WIDTH_DATA-1:0] lfsr_next_s;
  logic [WIDTH_DATA-1:0] lfsr_first_s;
  logic [WIDTH_DATA-1:0] first_sample_s;
  logic [WIDTH_DATA-1:0] next_sample_s;

  assign xfer_s    = (state_r == ST_RUN) && valid_r && sif.dout_ready;
  assign cnt_inc_s = cnt_r + LOG2_LEN'(1);

`ifdef FIR_STIM_LFSR_EN
  logic [WIDTH_DATA-1:0] seed_s;
  logic                  lfsr_load_s;

  // an all-zero seed would lock the LFSR, so it is replaced by 1
  assign seed_s       = (amplitude == {WIDTH_DATA{1'b0}}) ? WIDTH_DATA'(1) : amplitude;
  assign lfsr_load_s  = (state_r == ST_IDLE) && start;
  assign lfsr_first_s = seed_s;

  fir_stim_lfsr #(
    .WIDTH (WIDTH_DATA)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load_s),
    .seed    (seed_s),
    .advance (xfer_s),
    .state   (lfsr_next_s)
  );
`else
  assign lfsr_first_s = {WIDTH_DATA{1'b0}};
  assign lfsr_next_s  = {WIDTH_DATA{1'b0}};
`endif

  // sample 0 chosen from the live inputs at start
  always_comb begin
    first_sample_s = {WIDTH_DATA{1'b0}};
    case (mode)
      MODE_CONST:   first_sample_s = amplitude;
      MODE_IMPULSE: first_sample_s = amplitude;
      MODE_RAMP:    first_sample_s = {WIDTH_DATA{1'b0}};
      MODE_LFSR:    first_sample_s = lfsr_first_s;
      default:      first_sample_s = {WIDTH_DATA{1'b0}};
    endcase
  end

  // sample k+1 from the latched mode; the ramp accumulates on dout itself
  always_comb begin
    next_sample_s = {WIDTH_DATA{1'b0}};
    case (mode_r)
      MODE_CONST:   next_sample_s = amp_r;
      MODE_IMPULSE: next_sample_s = {WIDTH_DATA{1'b0}};
      MODE_RAMP:    next_sample_s = dout_r + amp_r;
      MODE_LFSR:    next_sample_s = lfsr_next_s;
      default:      next_sample_s = {WIDTH_DATA{1'b0}};
    endcase
  end

  // burst FSM with registered stream and status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      mode_r  <= MODE_CONST;
      amp_r   <= {WIDTH_DATA{1'b0}};
      dout_r  <= {WIDTH_DATA{1'b0}};
      len_r   <= {LOG2_LEN{1'b0}};
      cnt_r   <= {LOG2_LEN{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            mode_r <= mode_e'(mode);
            amp_r  <= amplitude;
            len_r  <= length;
            cnt_r  <= {LOG2_LEN{1'b0}};
            dout_r <= first_sample_s;
            busy_r <= 1'b1;
            if (length != {LOG2_LEN{1'b0}}) begin
              state_r <= ST_RUN;
              valid_r <= 1'b1;
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (xfer_s) begin
            cnt_r  <= cnt_inc_s;
            dout_r <= next_sample_s;
            if (cnt_inc_s == len_r) begin
              state_r <= ST_DONE;
              valid_r <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign sif.dout       = dout_r;
  assign sif.dout_valid = valid_r;
  assign busy           = busy_r;
  assign done           = done_r;

endmodule

// File: tb/tb_fir_stim_source.sv
// Directed bench for fir_stim_source; expected sample sequences are hand-computed.
module tb_fir_stim_source;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [7:0] amplitude;
  logic [7:0] length;
  logic       busy;
  logic       done;

  int n_checks;
  int n_errors;
  logic [7:0] exp_mem [0:15];

  fir_stim_if #(.WIDTH_DATA(8)) sif ();

  fir_stim_source #(
    .WIDTH_DATA (8),
    .LOG2_LEN   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .amplitude (amplitude),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .sif       (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a burst with ready held high and compares every transfer to exp_mem.
  task automatic run_burst(input string tag, input logic [1:0] m, input logic [7:0] a,
                           input logic [7:0] l);
    int n;
    int c;
    bit done_seen;
    n = 0;
    done_seen = 1'b0;
    sif.dout_ready = 1'b1;
    mode = m;
    amplitude = a;
    length = l;
    start = 1'b1;
    step();
    start = 1'b0;
    mode = ~m;
    amplitude = ~a;
    length = 8'd200;
    check({tag, " busy@n+1"}, busy, 1);
    for (c = 0; c < 40 && !done_seen; c++) begin
      if (sif.dout_valid) begin
        if (n < 16) check($sformatf("%s dout[%0d]", tag, n), sif.dout, exp_mem[n]);
        n++;
      end
      if (done) done_seen = 1'b1;
      else step();
    end
    check({tag, " done seen"}, done_seen, 1);
    check({tag, " transfers"}, n, l);
    check({tag, " done cycle"}, c - 1, l);
    check({tag, " busy in done"}, busy, 1);
    step();
    check({tag, " done width"}, done, 0);
    check({tag, " busy falls"}, busy, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    start = 1'b0;
    mode = 2'd0;
    amplitude = 8'd0;
    length = 8'd0;
    sif.dout_ready = 1'b0;
    step();
    step();
    check("rst dout", sif.dout, 0);
    check("rst valid", sif.dout_valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 4; i++) exp_mem[i] = 8'd5;
    run_burst("const", 2'd0, 8'd5, 8'd4);

    exp_mem[0] = 8'h7F;
    for (int i = 1; i < 16; i++) exp_mem[i] = 8'h00;
    run_burst("impulse", 2'd1, 8'h7F, 8'd16);

    exp_mem[0] = 8'h00; exp_mem[1] = 8'h40; exp_mem[2] = 8'h80;
    exp_mem[3] = 8'hC0; exp_mem[4] = 8'h00; exp_mem[5] = 8'h40;
    run_burst("ramp", 2'd2, 8'h40, 8'd6);

`ifdef FIR_STIM_LFSR_EN
    exp_mem[0] = 8'h01; exp_mem[1] = 8'hB8; exp_mem[2] = 8'h5C; exp_mem[3] = 8'h2E;
`else
    for (int i = 0; i < 4; i++) exp_mem[i] = 8'h00;
`endif
    run_burst("lfsr", 2'd3, 8'h00, 8'd4);

    run_burst("len0", 2'd0, 8'd9, 8'd0);

    // backpressure: stall after the first transfer, with a stray start
    sif.dout_ready = 1'b1;
    mode = 2'd0; amplitude = 8'h33; length = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    check("bp s0 valid", sif.dout_valid, 1);
    check("bp s0 dout", sif.dout, 8'h33);
    step();
    sif.dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp stall%0d valid", i), sif.dout_valid, 1);
      check($sformatf("bp stall%0d dout", i), sif.dout, 8'h33);
      check($sformatf("bp stall%0d done", i), done, 0);
      start = (i == 1);
      mode = 2'd2;
      amplitude = 8'h99;
      step();
      start = 1'b0;
    end
    sif.dout_ready = 1'b1;
    check("bp s1 dout", sif.dout, 8'h33);
    step();
    check("bp s2 valid", sif.dout_valid, 1);
    check("bp s2 dout", sif.dout, 8'h33);
    step();
    check("bp done", done, 1);
    check("bp valid after", sif.dout_valid, 0);
    step();
    check("bp idle busy", busy, 0);
    step();
    check("bp no restart valid", sif.dout_valid, 0);
    check("bp no restart busy", busy, 0);

    // reset after two of eight transfers
    mode = 2'd2; amplitude = 8'd3; length = 8'd8; start = 1'b1;
    step();
    start = 1'b0;
    check("rstmid s0", sif.dout, 8'd0);
    step();
    check("rstmid s1", sif.dout, 8'd3);
    step();
    check("rstmid s2", sif.dout, 8'd6);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rstmid valid", sif.dout_valid, 0);
    check("rstmid busy", busy, 0);
    check("rstmid dout", sif.dout, 0);
    check("rstmid done", done, 0);
    step();
    check("rstmid no done", done, 0);
    exp_mem[0] = 8'd0; exp_mem[1] = 8'd3;
    run_burst("restart", 2'd2, 8'd3, 8'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_stim_source.md
# fir_stim_source

Streaming sample generator that drives the FIR filter input. On a start request it emits a burst of `length` samples of a selected waveform (constant, impulse, ramp, pseudo-random) over a valid/ready handshake, then pulses `done`. It sits upstream of the FIR `din` port and is the producing end of the FIR sample interface, used for on-chip bring-up and for response characterisation.

## Interface
- `WIDTH_DATA`, default 8: sample width; matches the FIR `WIDTH_DATA`.
- `LOG2_LEN`, default 8: width of the burst-length field; maximum burst is 2^LOG2_LEN-1 samples.
- `clk`  input  1  single clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `start`  input  1  one-cycle request; sampled only in IDLE.
- `mode`  input  2  waveform select: 0 constant, 1 impulse, 2 ramp, 3 LFSR.
- `amplitude`  input  WIDTH_DATA  constant value, impulse height, ramp step, or LFSR seed.
- `length`  input  LOG2_LEN  number of samples in the burst.
- `dout`  output  WIDTH_DATA  sample data.
- `dout_valid`  output  1  `dout` is valid.
- `dout_ready`  input  1  consumer accepts the sample.
- `busy`  output  1  high whenever the FSM is not in IDLE.
- `done`  output  1  one-cycle pulse at the end of a burst.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - If `start` is high, latch `mode`, `amplitude` and `length`, clear the sample counter, and load the first sample.
  - Go to RUN if `length` is non-zero; otherwise go to DONE.
- **RUN**
  - `dout_valid` is 1.
  - A sample transfers on the clock edge where `dout_valid` and `dout_ready` are both high. On each transfer the counter increments and the next sample loads.
  - When the transfer is the one that makes count equal `length`, go to DONE and drop `dout_valid` in the same edge.
- **DONE**
  - `done` is 1 for exactly one cycle; go to IDLE next.
- **Waveforms** (k = sample index, starting at 0):
  - Constant: every sample equals `amplitude`.
  - Impulse: sample 0 equals `amplitude`; every later sample is 0.
  - Ramp: sample k = k·`amplitude` mod 2^WIDTH_DATA. Use a wrapping adder, not a multiplier.
  - LFSR: Galois LFSR of width WIDTH_DATA, seeded with `amplitude`. A seed of 0 is replaced by 1. For width 8 the taps are x^8+x^6+x^5+x^4+1. Sample 0 is the seed; the state advances once per transfer.
- `start` while `busy` is ignored; it is neither queued nor allowed to restart the burst.
- Latched parameters do not change during a burst, even if the inputs change.

## Timing
- Reset (`rst`=0 at an edge) puts the FSM in IDLE and drives `dout`=0, `dout_valid`=0, `busy`=0, `done`=0, counter=0.
- Reset mid-burst aborts the burst immediately; no `done` pulse is generated.
- Start latency: `start` high at edge n gives `dout_valid`=1 with sample 0 from n+1, and `busy`=1 from n+1.
- Throughput is one sample per cycle while `dout_ready` is held high.
- `dout` and `dout_valid` come straight from registers; there is no combinational path from `dout_ready` to `dout` or `dout_valid`.
- Backpressure: while `dout_valid`=1 and `dout_ready`=0, `dout` stays stable.
- `done` goes high on the cycle after the final transfer, and `busy` falls one cycle after that.
- `length`=0 gives `busy` for one cycle and `done` at n+1, with no `dout_valid`.

## Configuration
- `FIR_STIM_LFSR_EN` defined: mode 3 generates LFSR samples as described above, and the LFSR sub-module is instantiated.
- `FIR_STIM_LFSR_EN` undefined: the LFSR logic is absent. Mode 3 emits `length` samples of value 0 with the same handshake and timing.

## Structure
- Shared package `fir_stim_pkg` holds:
  - the mode encodings (MODE_CONST, MODE_IMPULSE, MODE_RAMP, MODE_LFSR);
  - the FSM state typedef;
  - the default LFSR tap mask for width 8.
- One sub-module, `fir_stim_lfsr`: a parameterised Galois LFSR with `load`, `seed` and `advance` inputs and a `state` output.

## Test plan
- Mode 0, `amplitude`=5, `length`=4, `dout_ready`=1 → `dout` reads 5,5,5,5 on cycles n+1 to n+4; `done` pulses at n+5.
- Mode 1, `amplitude`=0x7F, `length`=16 → `dout` reads 0x7F then fifteen 0s; exactly 16 transfers.
- Mode 2, `amplitude`=0x40, `length`=6 → `dout` reads 0x00,0x40,0x80,0xC0,0x00,0x40, showing wrap-around.
- Mode 0, `length`=3, `dout_ready` low for 3 cycles after the first transfer → `dout` holds steady while stalled; only 3 transfers occur; `done` comes after the third; a `start` pulsed while stalled is ignored.
- Mode 3, `amplitude`=0, `length`=4 → first sample 0x01 (seed substituted) followed by the LFSR sequence. With the macro undefined the samples are 0,0,0,0.
- `rst`=0 mid-burst after 2 of 8 transfers → next cycle `dout_valid`=0, `busy`=0, `dout`=0, no `done`; a new `start` afterwards begins cleanly from sample 0.
